alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execute-stage ALU for the MIPS datapath.
- Takes two 32-bit operands and a 3-bit control code from the ALU control unit.
- Produces a registered 32-bit result, a zero flag (consumed by branch logic) and a signed-overflow flag.
- One clock, one-cycle latency, valid-qualified pipeline register on the outputs.

Parameters:
- WIDTH, 32, operand/result width in bits. All behaviour below is specified for 32; other values must scale identically.

Ports:
- iClk  input  1  rising-edge clock
- iRst_n  input  1  asynchronous active-low reset
- iValid  input  1  operands/control valid this cycle
- iA  input  32  operand A (rs)
- iB  input  32  operand B (rt or sign-extended immediate)
- iALUctrl  input  3  operation select
- res  output  32  registered result
- zero  output  1  registered; 1 when res == 0
- oOverflow  output  1  registered signed overflow, ADD/SUB only
- oValid  output  1  res/zero/oOverflow valid

Behaviour:
- Reset (iRst_n low, asynchronous, takes effect immediately regardless of clock):
  - res = 0, zero = 1, oOverflow = 0, oValid = 0.
  - Held while iRst_n is low.
  - First capture occurs on the first rising iClk after deassertion.
- Operation encoding, computed combinationally from iA/iB/iALUctrl:
  - 000 AND: iA & iB
  - 001 OR: iA | iB
  - 010 ADD: iA + iB, modulo 2^32
  - 011 XOR: iA ^ iB
  - 100 NOR: ~(iA | iB)
  - 101 SLTU: 1 if iA < iB unsigned, else 0 (zero-extended to 32 bits)
  - 110 SUB: iA - iB, modulo 2^32
  - 111 SLT: 1 if iA < iB signed two's complement, else 0 (zero-extended)
- SLT must be correct when the subtraction overflows. Use the sign of the true difference, i.e. (A[31] != B[31]) ? A[31] : diff[31].
- Overflow:
  - ADD: set when A[31] == B[31] and sum[31] != A[31].
  - SUB: set when A[31] != B[31] and diff[31] != A[31].
  - All other ops: 0.
  - Overflow only flags; it never traps and never alters res.
- Register update, on each rising iClk with iRst_n high:
  - iValid = 1: res, zero and oOverflow take the new combinational values; oValid <= 1.
  - iValid = 0: res, zero and oOverflow hold their previous values; oValid <= 0.
- Latency: exactly 1 cycle from input sample to output.
- Throughput: one operation per cycle; back-to-back iValid accepted with no stall and no backpressure.
- zero always equals (res == 0) for the registered res, including after reset.
- X/undriven control is not a legal input. For any legal code the output is fully defined; no latches.
- Reset asserted mid-stream clears the outputs immediately. The in-flight operation is discarded.

Test Plan:
- Reset check: hold iRst_n = 0, toggle clock -> res = 0, zero = 1, oValid = 0, oOverflow = 0. Assert iRst_n asynchronously between edges -> outputs clear without waiting for a clock edge.
- iA = 0x00000000, iB = 0xDEADBEEF, iValid = 1, stepping iALUctrl through AND/SUB/ADD/OR/SLT/SLTU. Required outputs one cycle later:
  - AND -> res 0x00000000, zero 1
  - SUB -> 0x21524111, zero 0, ovf 0
  - ADD -> 0xDEADBEEF
  - OR -> 0xDEADBEEF
  - SLT -> 0x00000000, zero 1 (0 is not less than the negative B)
  - SLTU -> 0x00000001
- Overflow:
  - ADD 0x7FFFFFFF + 0x00000001 -> res 0x80000000, oOverflow 1.
  - SUB 0x80000000 - 0x00000001 -> res 0x7FFFFFFF, oOverflow 1.
  - SLT with the same SUB operands -> 0x00000001.
- Logic ops with A = 0xF0F0F0F0, B = 0x0FF00FF0:
  - XOR -> 0xFF00FF00
  - NOR -> 0x000F000F
  - SUB A - A -> 0, zero 1
- Handshake: valid op, then iValid = 0 for 2 cycles with changed inputs -> oValid drops to 0 and res/zero hold the previous values.
- Handshake: back-to-back iValid with a different op each cycle -> each result appears exactly one cycle later in order.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: MIPS execute-stage ALU with a valid-qualified, one-cycle output register.
`timescale 1ns/1ps

module alu_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [2:0]       iALUctrl,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             oOverflow,
  output logic             oValid
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign sum         = iA + iB;
  assign diff        = iA - iB;
  // Sign of the true difference, so SLT stays correct when the subtraction overflows.
  assign lt_signed   = (iA[MSB] != iB[MSB]) ? iA[MSB] : diff[MSB];
  assign lt_unsigned = (iA < iB);

  // Operation select and signed-overflow detection for ADD/SUB.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (iALUctrl)
      OP_AND:  alu_res = iA & iB;
      OP_OR:   alu_res = iA | iB;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (iA[MSB] == iB[MSB]) && (sum[MSB] != iA[MSB]);
      end
      OP_XOR:  alu_res = iA ^ iB;
      OP_NOR:  alu_res = ~(iA | iB);
      OP_SLTU: alu_res = WIDTH'(lt_unsigned);
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (iA[MSB] != iB[MSB]) && (diff[MSB] != iA[MSB]);
      end
      OP_SLT:  alu_res = WIDTH'(lt_signed);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Output pipeline register: captures on valid, holds data otherwise; reset forces res=0/zero=1.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      res       <= '0;
      zero      <= 1'b1;
      oOverflow <= 1'b0;
      oValid    <= 1'b0;
    end else begin
      oValid <= iValid;
      if (iValid) begin
        res       <= alu_res;
        zero      <= (alu_res == '0);
        oOverflow <= alu_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector bench for alu_exec with hand-computed expected values.
`timescale 1ns/1ps

module tb_alu_exec;

  logic        iClk;
  logic        iRst_n;
  logic        iValid;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [2:0]  iALUctrl;
  logic [31:0] res;
  logic        zero;
  logic        oOverflow;
  logic        oValid;

  int total;
  int bad;

  localparam logic [2:0] C_AND  = 3'b000;
  localparam logic [2:0] C_OR   = 3'b001;
  localparam logic [2:0] C_ADD  = 3'b010;
  localparam logic [2:0] C_XOR  = 3'b011;
  localparam logic [2:0] C_NOR  = 3'b100;
  localparam logic [2:0] C_SLTU = 3'b101;
  localparam logic [2:0] C_SUB  = 3'b110;
  localparam logic [2:0] C_SLT  = 3'b111;

  alu_exec #(.WIDTH(32)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iValid    (iValid),
    .iA        (iA),
    .iB        (iB),
    .iALUctrl  (iALUctrl),
    .res       (res),
    .zero      (zero),
    .oOverflow (oOverflow),
    .oValid    (oValid)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation at the falling edge, then sample #1 after the next rising edge.
  task automatic apply(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge iClk);
    iValid   = v;
    iALUctrl = c;
    iA       = a;
    iB       = b;
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic z,
                         input logic ovf, input logic v);
    chk({tag, ".res"},  res,              r);
    chk({tag, ".zero"}, {31'd0, zero},      {31'd0, z});
    chk({tag, ".ovf"},  {31'd0, oOverflow}, {31'd0, ovf});
    chk({tag, ".vld"},  {31'd0, oValid},    {31'd0, v});
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    iRst_n   = 1'b0;
    iValid   = 1'b1;
    iA       = 32'h1234_5678;
    iB       = 32'h0000_0001;
    iALUctrl = C_ADD;

    // Reset held across several clocks, even with valid inputs present.
    repeat (3) @(posedge iClk);
    #1;
    chk_out("reset_hold", 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge iClk);
    iRst_n = 1'b1;

    // A = 0, B = 0xDEADBEEF through AND/SUB/ADD/OR/SLT/SLTU.
    apply(1'b1, C_AND,  32'h0, 32'hDEAD_BEEF); chk_out("and0",  32'h0000_0000, 1'b1, 1'b0, 1'b1);
    apply(1'b1, C_SUB,  32'h0, 32'hDEAD_BEEF); chk_out("sub0",  32'h2152_4111, 1'b0, 1'b0, 1'b1);
    apply(1'b1, C_ADD,  32'h0, 32'hDEAD_BEEF); chk_out("add0",  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    apply(1'b1, C_OR,   32'h0, 32'hDEAD_BEEF); chk_out("or0",   32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    apply(1'b1, C_SLT,  32'h0, 32'hDEAD_BEEF); chk_out("slt0",  32'h0000_0000, 1'b1, 1'b0, 1'b1);
    apply(1'b1, C_SLTU, 32'h0, 32'hDEAD_BEEF); chk_out("sltu0", 32'h0000_0001, 1'b0, 1'b0, 1'b1);

    // Signed overflow and SLT across an overflowing subtraction.
    apply(1'b1, C_ADD, 32'h7FFF_FFFF, 32'h0000_0001); chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    apply(1'b1, C_SUB, 32'h8000_0000, 32'h0000_0001); chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    apply(1'b1, C_SLT, 32'h8000_0000, 32'h0000_0001); chk_out("slt_ovf", 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    apply(1'b1, C_SLTU, 32'h8000_0000, 32'h0000_0001); chk_out("sltu_big", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    // Overflow flag must stay low on a logic op even when ADD of the same operands would overflow.
    apply(1'b1, C_OR, 32'h7FFF_FFFF, 32'h0000_0001); chk_out("or_noovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);

    // Logic ops, back-to-back with a different op every cycle.
    apply(1'b1, C_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0); chk_out("xor", 32'hFF00_FF00, 1'b0, 1'b0, 1'b1);
    apply(1'b1, C_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0); chk_out("nor", 32'h000F_000F, 1'b0, 1'b0, 1'b1);
    apply(1'b1, C_SUB, 32'hF0F0_F0F0, 32'hF0F0_F0F0); chk_out("sub_self", 32'h0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0); chk_out("and_mix", 32'h00F0_00F0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, C_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0); chk_out("or_mix",  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b1);

    // Valid op, then two idle cycles with changed inputs: data holds, valid drops.
    apply(1'b1, C_ADD, 32'h0000_0005, 32'h0000_0007); chk_out("pre_hold", 32'h0000_000C, 1'b0, 1'b0, 1'b1);
    apply(1'b0, C_SUB, 32'h0000_0003, 32'h0000_0003); chk_out("hold1",    32'h0000_000C, 1'b0, 1'b0, 1'b0);
    apply(1'b0, C_ADD, 32'h7FFF_FFFF, 32'h0000_0001); chk_out("hold2",    32'h0000_000C, 1'b0, 1'b0, 1'b0);
    apply(1'b1, C_SUB, 32'h0000_0003, 32'h0000_0003); chk_out("resume",   32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Overflowing op then async reset between clock edges: outputs clear immediately.
    apply(1'b1, C_ADD, 32'h7FFF_FFFF, 32'h0000_0001); chk_out("pre_rst", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    @(negedge iClk);
    #2;
    iRst_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge iClk);
    iRst_n = 1'b1;

    // First capture after release.
    apply(1'b1, C_XOR, 32'hAAAA_AAAA, 32'h5555_5555); chk_out("post_rst", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
